serial_tx_shifter: RTL
======================

// Module: serial_tx_shifter
// PURPOSE
//  Parallel-in/serial-out transmitter; the sending end of the lab's serial bit link.
//  - Accepts a WIDTH-bit word over a valid/ready load handshake.
//  - Drives it out one bit per clk cycle, with a frame strobe and a done pulse.
//  - Feeds a receive shift chain built from falling-edge D flip-flops. This block updates
//    on the rising edge, giving the receiver a half-cycle of setup/hold margin.
// PARAMETERS
//  WIDTH      8   word length in bits; legal range 1..32
//  MSB_FIRST  1   1: send bit WIDTH-1 first; 0: send bit 0 first
// PORTS
//  clk         in   1      clock; every register updates on the rising edge
//  reset       in   1      reset, asynchronous, active-high
//  load_valid  in   1      load_data is valid this cycle
//  load_data   in   WIDTH  word to transmit
//  load_ready  out  1      block can accept a word (high only in IDLE)
//  ser_out     out  1      serial data bit, registered
//  ser_frame   out  1      high on every cycle ser_out carries a data bit
//  done        out  1      one-cycle pulse in the cycle after the last data bit
// BEHAVIOUR
//  - Reset (async, asserts immediately, any state): state=IDLE, shift reg=0, count=0,
//    ser_out=0, ser_frame=0, done=0. load_ready=1 while reset is low and state is IDLE.
//  - States: IDLE, SHIFT. Encoding is binary, 1 bit.
//  - IDLE: load_ready=1, ser_frame=0, ser_out=0.
//    load_valid=1 at a rising edge -> capture load_data, count=WIDTH-1, go to SHIFT.
//    load_valid=0 -> stay in IDLE.
//  - SHIFT: load_ready=0; load_valid is ignored and the word is not captured.
//    On each edge, drive the next bit onto ser_out and shift the register by one.
//    At count==0, the next edge goes to IDLE and sets done=1 for exactly that one cycle.
//  - Latency: accept edge E.
//    Data bit k (k=0..WIDTH-1, in send order) is valid on ser_out for the cycle after
//    edge E+k. ser_frame=1 for exactly WIDTH cycles. done=1 in the cycle after edge E+WIDTH.
//  - Throughput: done and load_ready are high together. A word accepted in the done
//    cycle starts its frame on the next cycle, so words are WIDTH+1 cycles apart.
//    ser_frame drops for exactly one cycle between words.
//  - Bit order: MSB_FIRST=1 shifts left and sends reg[WIDTH-1].
//    MSB_FIRST=0 shifts right and sends reg[0]. Vacated bits fill with 0.
//  - Counter width: $clog2(WIDTH), minimum 1 bit. It never wraps: load sets it and it
//    counts down to 0 only.
//  - WIDTH=1: one frame cycle, then done. The same rules apply.
//  - load_data changing while in SHIFT has no effect.
//  - Reset mid-frame: ser_frame and ser_out drop to 0 at once, with no done pulse.
//    The partial word is discarded.
// STRUCTURE
//  - Shared package serial_link_pkg:
//    - localparams ST_IDLE=1'b0 and ST_SHIFT=1'b1.
//    - Default link WIDTH constant. The receiver uses the same package.
//  - One sub-module, tx_shift_reg: WIDTH-bit loadable shift register.
//    - Ports: clk, reset, load, shift, din, msb_first; outputs q and sbit.
//    - serial_tx_shifter holds the FSM, the counter and the output registers.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1, load 8'h0F.
//     -> ser_out=0,0,0,0,1,1,1,1 on cycles 1..8; ser_frame high cycles 1..8;
//        done=1 on cycle 9 only.
//  2. MSB_FIRST=0, load 8'h0F.
//     -> ser_out=1,1,1,1,0,0,0,0; frame and done timing identical to scenario 1.
//  3. Hold load_valid=1 with 8'hA5, then 8'h3C.
//     -> second word accepted on the done cycle; exactly one ser_frame=0 cycle between words;
//        A5 and 3C bit streams both exact.
//  4. Pulse load_valid with 8'hFF during SHIFT of word 8'h00.
//     -> 8'hFF is ignored; 8 zeros are sent, then IDLE.
//  5. Assert reset asynchronously in cycle 4 of an 8'hC3 frame.
//     -> ser_frame, ser_out and done are 0 before the next edge; no done pulse.
//        After release, load 8'h81 is sent cleanly.
//  6. Loop back into a falling-edge receive shift register; send 8'h5A, then WIDTH=1 words 1 and 0.
//     -> receiver captures 8'h5A. For WIDTH=1: frame high for 1 cycle, done on cycle 2.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Definitions shared by both ends of the serial bit link.
// Holds the FSM state codes and the default word length.
package serial_link_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam int LINK_WIDTH = 8;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT
   } tx_state_e;

endpackage

// File: rtl/serial_tx_shifter_tx_shift_reg.sv
// Loadable shift register for the serial transmitter.
// A load captures din already advanced by one bit, because the first bit is sent straight from din.
module tx_shift_reg import serial_link_pkg::*; #(
   parameter int WIDTH = LINK_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   input  logic             msb_first,
   output logic [WIDTH-1:0] q,
   output logic             sbit
);

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] src;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      src    = load ? din : q_reg;
      q_next = msb_first ? (src << 1) : (src >> 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg <= '0;
      end else if (load || shift) begin
         q_reg <= q_next;
      end
   end

   assign q    = q_reg;
   assign sbit = msb_first ? q_reg[WIDTH-1] : q_reg[0];

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clock,
// frame strobe while data is on the line and a one-cycle done pulse afterwards.
module serial_tx_shifter import serial_link_pkg::*; #(
   parameter int WIDTH     = LINK_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_frame,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   tx_state_e        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             ser_out_reg, ser_out_next;
   logic             ser_frame_reg, ser_frame_next;
   logic             done_reg, done_next;
   logic             sr_load, sr_shift, sr_sbit;
   logic [WIDTH-1:0] sr_q_unused;
   logic             first_bit;

   assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];

   tx_shift_reg #(
      .WIDTH(WIDTH)
   ) u_shift_reg (
      .clk      (clk),
      .reset    (reset),
      .load     (sr_load),
      .shift    (sr_shift),
      .din      (load_data),
      .msb_first(MSB_FIRST),
      .q        (sr_q_unused),
      .sbit     (sr_sbit)
   );

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ser_out_next   = 1'b0;
      ser_frame_next = 1'b0;
      done_next      = 1'b0;
      sr_load        = 1'b0;
      sr_shift       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (load_valid) begin
               sr_load        = 1'b1;
               state_next     = S_SHIFT;
               cnt_next       = CNT_W'(WIDTH - 1);
               ser_out_next   = first_bit;
               ser_frame_next = 1'b1;
            end
         end
         S_SHIFT: begin
            // cnt_reg counts the bits still to be put on the line after the current one
            if (cnt_reg == '0) begin
               state_next = S_IDLE;
               done_next  = 1'b1;
            end else begin
               sr_shift       = 1'b1;
               cnt_next       = cnt_reg - 1'b1;
               ser_out_next   = sr_sbit;
               ser_frame_next = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         ser_out_reg   <= 1'b0;
         ser_frame_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ser_out_reg   <= ser_out_next;
         ser_frame_reg <= ser_frame_next;
         done_reg      <= done_next;
      end
   end

   assign load_ready = (state_reg == S_IDLE) && !reset;
   assign ser_out    = ser_out_reg;
   assign ser_frame  = ser_frame_reg;
   assign done       = done_reg;

endmodule
